// File: rtl/dctq_zigzag_rle_if.sv
// Coefficient input, stall feedback and (run, level) output bundle of dctq_zigzag_rle.
// master = producer/consumer environment, slave = the zigzag/RLE block.
interface dctq_zigzag_rle_if #(
  parameter int CW   = 9,
  parameter int RUNW = 6
);
  logic [CW-1:0]   dctq;
  logic            dctq_valid;
  logic [5:0]      addr;
  logic            hold;
  logic            rl_valid;
  logic            rl_ready;
  logic [RUNW-1:0] rl_run;
  logic signed [CW:0] rl_level;
  logic            rl_eob;
  logic            overflow;

  modport master (
    output dctq, dctq_valid, addr, rl_ready,
    input  hold, rl_valid, rl_run, rl_level, rl_eob, overflow
  );

  modport slave (
    input  dctq, dctq_valid, addr, rl_ready,
    output hold, rl_valid, rl_run, rl_level, rl_eob, overflow
  );
endinterface

// File: rtl/dctq_zigzag_rle.sv
// Ping-pong 8x8 coefficient buffer, read back in zigzag order as (run, level) pairs + EOB.
// Optional macro DC_DPCM_EN: DC level is emitted as the difference from the previous block's DC.
module dctq_zigzag_rle #(
  parameter int CW   = 9,
  parameter int RUNW = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  dctq_zigzag_rle_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, EOB, DRAIN} state_t;

  // Raster address visited at each zigzag position.
  localparam logic [5:0] ZZ_ROM [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [CW-1:0]   mem [128];
  logic [CW-1:0]   rd_data;
  logic [1:0]      full_reg, full_next;
  logic            wr_bank_reg, rd_bank_reg;
  logic            hold_reg, overflow_reg;
  state_t          state_reg, state_next;
  logic [5:0]      zz_idx_reg;
  logic            p1_valid_reg, p1_eob_reg, p1_dc_reg;
  logic [RUNW-1:0] run_reg;
  logic            rl_valid_reg, rl_eob_reg;
  logic [RUNW-1:0] rl_run_reg;
  logic [CW:0]     rl_level_reg;
  logic            advance, wr_ok, eob_accept, rd_en, emit;
  logic [CW:0]     level_ext, dc_level;

  // Everything downstream of the zigzag address freezes while the output is back-pressured.
  assign advance    = !(rl_valid_reg && !bus.rl_ready);
  assign wr_ok      = bus.dctq_valid && !full_reg[wr_bank_reg];
  assign eob_accept = rl_valid_reg && bus.rl_ready && rl_eob_reg;
  assign rd_en      = advance && (state_reg == SCAN);

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[{wr_bank_reg, bus.addr}] <= bus.dctq;
    if (rd_en)
      rd_data <= mem[{rd_bank_reg, ZZ_ROM[zz_idx_reg]}];
  end

  always_comb begin
    full_next = full_reg;
    if (eob_accept)
      full_next[rd_bank_reg] = 1'b0;
    if (wr_ok && bus.addr == 6'd63)
      full_next[wr_bank_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_reg     <= '0;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      hold_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      hold_reg <= &full_next;
      if (wr_ok && bus.addr == 6'd63)
        wr_bank_reg <= ~wr_bank_reg;
      if (bus.dctq_valid && full_reg[wr_bank_reg])
        overflow_reg <= 1'b1;
      if (eob_accept)
        rd_bank_reg <= ~rd_bank_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (full_reg[rd_bank_reg]) state_next = SCAN;
      SCAN:    if (advance && zz_idx_reg == 6'd63) state_next = EOB;
      EOB:     if (advance) state_next = DRAIN;
      DRAIN:   if (eob_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef DC_DPCM_EN
  logic [CW-1:0] pred_reg, rl_dc_raw_reg;
  logic          rl_dc_reg;

  // The predictor only moves once the DC pair has actually left the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_reg      <= '0;
      rl_dc_raw_reg <= '0;
      rl_dc_reg     <= 1'b0;
    end else begin
      if (advance && emit) begin
        rl_dc_reg     <= p1_dc_reg;
        rl_dc_raw_reg <= rd_data;
      end
      if (rl_valid_reg && bus.rl_ready && rl_dc_reg)
        pred_reg <= rl_dc_raw_reg;
    end
  end
`endif

  always_comb begin
    level_ext = {rd_data[CW-1], rd_data};
`ifdef DC_DPCM_EN
    dc_level  = level_ext - {pred_reg[CW-1], pred_reg};
`else
    dc_level  = level_ext;
`endif
    emit      = p1_valid_reg && (p1_eob_reg || p1_dc_reg || rd_data != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      zz_idx_reg   <= '0;
      p1_valid_reg <= 1'b0;
      p1_eob_reg   <= 1'b0;
      p1_dc_reg    <= 1'b0;
      run_reg      <= '0;
      rl_valid_reg <= 1'b0;
      rl_eob_reg   <= 1'b0;
      rl_run_reg   <= '0;
      rl_level_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE)
        zz_idx_reg <= '0;
      else if (rd_en)
        zz_idx_reg <= zz_idx_reg + 6'd1;
      if (advance) begin
        // Stage 1 carries either a coefficient read or the end-of-block token.
        p1_valid_reg <= (state_reg == SCAN) || (state_reg == EOB);
        p1_eob_reg   <= (state_reg == EOB);
        p1_dc_reg    <= (state_reg == SCAN) && (zz_idx_reg == 6'd0);
        rl_valid_reg <= emit;
        if (emit) begin
          rl_eob_reg   <= p1_eob_reg;
          rl_run_reg   <= (p1_eob_reg || p1_dc_reg) ? '0 : run_reg;
          rl_level_reg <= p1_eob_reg ? '0 : (p1_dc_reg ? dc_level : level_ext);
        end
        if (p1_valid_reg && !p1_eob_reg)
          run_reg <= emit ? '0 : run_reg + RUNW'(1);
      end
    end
  end

  assign bus.hold     = hold_reg;
  assign bus.overflow = overflow_reg;
  assign bus.rl_valid = rl_valid_reg;
  assign bus.rl_eob   = rl_eob_reg;
  assign bus.rl_run   = rl_run_reg;
  assign bus.rl_level = rl_level_reg;
endmodule

// File: tb/tb_dctq_zigzag_rle.sv
// Self-checking bench for dctq_zigzag_rle: directed vector table, stall/overflow/reset sequences,
// and random blocks checked against a diagonal-walk zigzag/RLE reference model.
module tb_dctq_zigzag_rle;
  localparam int CW   = 9;
  localparam int RUNW = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dctq_zigzag_rle_if #(.CW(CW), .RUNW(RUNW)) bus ();
  dctq_zigzag_rle #(.CW(CW), .RUNW(RUNW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct { int run; int level; bit eob; } rl_t;
  typedef struct { int n_nz; int a[3]; int v[3]; int n_exp; int er[4]; int el[4]; } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  rl_t  out_q[$];
  rl_t  exp_q[$];
  int   eob_seen = 0;
  int   blk[64];
  int   zz_ord[64];
  int   model_pred = 0;
  bit   rand_mode = 1'b0;
  bit   ready_force = 1'b1;
  bit   rnd_bit = 1'b1;
  vec_t vecs[4];

  assign bus.rl_ready = rand_mode ? rnd_bit : ready_force;
  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Collect accepted outputs and verify outputs stay frozen while stalled.
  rl_t prev_out;
  bit  prev_stall = 1'b0;
  always @(negedge clk) begin
    rl_t cur;
    cur.run   = int'(bus.rl_run);
    cur.level = int'($signed(bus.rl_level));
    cur.eob   = bus.rl_eob;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(bus.rl_valid), 1);
        check("stall_run", cur.run, prev_out.run);
        check("stall_level", cur.level, prev_out.level);
        check("stall_eob", int'(cur.eob), int'(prev_out.eob));
      end
      if (bus.rl_valid && bus.rl_ready) begin
        out_q.push_back(cur);
        if (cur.eob) eob_seen++;
      end
      prev_stall = bus.rl_valid && !bus.rl_ready;
      prev_out   = cur;
    end
  end

  // Zigzag order derived by walking the anti-diagonals of the 8x8 block.
  task automatic build_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 8) ? s : 7;
      for (int j = 0; j <= hi - lo; j++) begin
        int r = (s % 2 == 0) ? hi - j : lo + j;
        zz_ord[k] = r * 8 + (s - r);
        k++;
      end
    end
  endtask

  task automatic model_block();
    int run = 0;
    int dc = blk[zz_ord[0]];
    rl_t e;
`ifdef DC_DPCM_EN
    e = '{0, dc - model_pred, 1'b0};
    model_pred = dc;
`else
    e = '{0, dc, 1'b0};
`endif
    exp_q.push_back(e);
    for (int i = 1; i < 64; i++) begin
      if (blk[zz_ord[i]] == 0) begin
        run++;
      end else begin
        e = '{run, blk[zz_ord[i]], 1'b0};
        exp_q.push_back(e);
        run = 0;
      end
    end
    e = '{0, 0, 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic gen_block(input int mode);
    for (int i = 0; i < 64; i++) begin
      int v = int'($urandom_range(0, 511)) - 256;
      if (mode == 0) blk[i] = 0;
      else if (mode == 1) blk[i] = (v == 0) ? 1 : v;
      else blk[i] = ($urandom_range(0, 4) == 0) ? v : 0;
    end
  endtask

  task automatic clear_block();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic clear_q();
    out_q.delete();
    exp_q.delete();
    eob_seen = 0;
  endtask

  task automatic write_block(input bit obey_hold);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (obey_hold) begin
        int w = 0;
        while (bus.hold && w < 2000) begin
          bus.dctq_valid = 1'b0;
          @(posedge clk); #1;
          w++;
        end
        if (w >= 2000) check("hold_timeout", 1, 0);
      end
      bus.dctq_valid = 1'b1;
      bus.addr       = 6'(i);
      bus.dctq       = CW'(blk[i]);
    end
    @(posedge clk); #1;
    bus.dctq_valid = 1'b0;
  endtask

  task automatic wait_eobs(input int n, input string name);
    int c = 0;
    while (eob_seen < n && c < 4000) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    check({name, "_eob_timeout"}, int'(eob_seen >= n), 1);
  endtask

  task automatic compare_queues(input string name);
    check({name, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d].run", name, i), out_q[i].run, exp_q[i].run);
      check($sformatf("%s[%0d].level", name, i), out_q[i].level, exp_q[i].level);
      check($sformatf("%s[%0d].eob", name, i), int'(out_q[i].eob), int'(exp_q[i].eob));
    end
    clear_q();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.dctq_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_pred = 0;
    clear_q();
  endtask

  task automatic load_vec(input int t);
    clear_block();
    for (int k = 0; k < vecs[t].n_nz; k++) blk[vecs[t].a[k]] = vecs[t].v[k];
  endtask

  task automatic expect_vec(input int t);
    rl_t e;
    for (int k = 0; k < vecs[t].n_exp; k++) begin
      e = '{vecs[t].er[k], vecs[t].el[k], 1'b0};
      exp_q.push_back(e);
    end
    e = '{0, 0, 1'b1};
    exp_q.push_back(e);
  endtask

  function automatic vec_t mk_vec(input int n_nz, input int a0, v0, a1, v1, a2, v2,
                                  input int n_exp, input int r0, l0, r1, l1, r2, l2, r3, l3);
    vec_t x;
    x.n_nz  = n_nz;
    x.a     = '{a0, a1, a2};
    x.v     = '{v0, v1, v2};
    x.n_exp = n_exp;
    x.er    = '{r0, r1, r2, r3};
    x.el    = '{l0, l1, l2, l3};
    return x;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc_in[3] = '{10, 7, 7};
`ifdef DC_DPCM_EN
    int dc_exp[3] = '{10, -3, 0};
`else
    int dc_exp[3] = '{10, 7, 7};
`endif
    int w;

    bus.dctq = '0;
    bus.dctq_valid = 1'b0;
    bus.addr = '0;
    build_zigzag();

    vecs[0] = mk_vec(1, 0, 5, 0, 0, 0, 0,       1, 0, 5, 0, 0, 0, 0, 0, 0);
    vecs[1] = mk_vec(3, 1, -3, 8, 7, 2, 4,      4, 0, 0, 0, -3, 0, 7, 2, 4);
    vecs[2] = mk_vec(2, 0, 2, 63, -1, 0, 0,     2, 0, 2, 62, -1, 0, 0, 0, 0);
    vecs[3] = mk_vec(2, 0, -256, 3, 255, 0, 0,  2, 0, -256, 5, 255, 0, 0, 0, 0);

    // Reset values, observed while reset is held.
    repeat (3) @(negedge clk);
    check("rst_hold", int'(bus.hold), 0);
    check("rst_rl_valid", int'(bus.rl_valid), 0);
    check("rst_rl_run", int'(bus.rl_run), 0);
    check("rst_rl_level", int'(bus.rl_level), 0);
    check("rst_rl_eob", int'(bus.rl_eob), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed vector table (T1..T3 plus extreme levels).
    for (int t = 0; t < 4; t++) begin
      do_reset();
      ready_force = 1'b1;
      load_vec(t);
      write_block(1'b0);
      if (t == 0) begin
        repeat (3) @(negedge clk);
        check("t1_latency_early", int'(bus.rl_valid), 0);
        @(negedge clk);
        check("t1_latency_valid", int'(bus.rl_valid), 1);
        check("t1_latency_level", int'($signed(bus.rl_level)), 5);
      end
      wait_eobs(1, $sformatf("vec%0d", t));
      expect_vec(t);
      compare_queues($sformatf("vec%0d", t));
      check($sformatf("vec%0d_overflow", t), int'(bus.overflow), 0);
    end

    // T4: stall for 10 cycles after the first pair.
    do_reset();
    ready_force = 1'b0;
    load_vec(1);
    write_block(1'b0);
    w = 0;
    while (!bus.rl_valid && w < 20) begin @(negedge clk); w++; end
    check("t4_first_valid", int'(bus.rl_valid), 1);
    @(posedge clk); #1; ready_force = 1'b1;
    @(posedge clk); #1; ready_force = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_held_valid", int'(bus.rl_valid), 1);
    check("t4_held_run", int'(bus.rl_run), 0);
    check("t4_held_level", int'($signed(bus.rl_level)), -3);
    @(posedge clk); #1; ready_force = 1'b1;
    wait_eobs(1, "t4");
    expect_vec(1);
    compare_queues("t4");
    check("t4_overflow", int'(bus.overflow), 0);

    // T5: three blocks with no downstream acceptance.
    do_reset();
    ready_force = 1'b0;
    gen_block(2); model_block(); write_block(1'b0);
    @(negedge clk);
    check("t5_hold_one_bank", int'(bus.hold), 0);
    gen_block(2); model_block(); write_block(1'b0);
    @(negedge clk);
    check("t5_hold_both_full", int'(bus.hold), 1);
    check("t5_overflow_before", int'(bus.overflow), 0);
    gen_block(1); write_block(1'b0);
    @(negedge clk);
    check("t5_overflow_set", int'(bus.overflow), 1);
    @(posedge clk); #1; ready_force = 1'b1;
    wait_eobs(2, "t5");
    compare_queues("t5");
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("t5_idle_valid", int'(bus.rl_valid), 0);
    check("t5_idle_hold", int'(bus.hold), 0);
    check("t5_no_extra", out_q.size(), 0);
    check("t5_overflow_sticky", int'(bus.overflow), 1);

    // Random blocks with random back-pressure; producer honours hold.
    do_reset();
    rand_mode = 1'b1;
    for (int b = 0; b < 10; b++) begin
      gen_block((b < 2) ? b : 2);
      model_block();
      write_block(1'b1);
    end
    wait_eobs(10, "rnd");
    rand_mode = 1'b0;
    compare_queues("rnd");
    check("rnd_overflow", int'(bus.overflow), 0);

    // T6: DC handling across consecutive blocks.
    do_reset();
    ready_force = 1'b1;
    for (int b = 0; b < 3; b++) begin
      clear_block();
      blk[0] = dc_in[b];
      blk[1] = b + 1;
      write_block(1'b0);
      wait_eobs(1, $sformatf("t6_b%0d", b));
      if (out_q.size() > 0)
        check($sformatf("t6_dc%0d", b), out_q[0].level, dc_exp[b]);
      else
        check($sformatf("t6_dc%0d_present", b), 0, 1);
      clear_q();
    end

    // Reset in the middle of a scan discards the block and the predictor.
    ready_force = 1'b0;
    gen_block(2);
    blk[0] = 33;
    write_block(1'b0);
    w = 0;
    while (!bus.rl_valid && w < 20) begin @(negedge clk); w++; end
    check("t6_midscan_valid", int'(bus.rl_valid), 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("t6_reset_valid", int'(bus.rl_valid), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_pred = 0;
    clear_q();
    ready_force = 1'b1;
    gen_block(2);
    blk[0] = 9;
    model_block();
    write_block(1'b0);
    wait_eobs(1, "t6_post");
    if (out_q.size() > 0)
      check("t6_post_dc_raw", out_q[0].level, 9);
    else
      check("t6_post_dc_present", 0, 1);
    compare_queues("t6_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
